// File: rtl/display_source_arbiter.sv
// Shares the 4-bit LED / 7-segment path between SPI words and the switch decoder.
// A priority FSM with a hold timer, a decoder stability filter and a static output override.
module display_source_arbiter #(
  parameter int HOLD_CYCLES       = 50_000_000,
  parameter int DEC_STABLE_CYCLES = 500_000
) (
  input  logic       FPGA_clk,
  input  logic       FPGA_reset,
  input  logic [3:0] spi_data_in,
  input  logic       spi_valid_in,
  input  logic [1:0] dec_in,
  input  logic [1:0] force_src_in,
  output logic [3:0] disp_value_out,
  output logic       disp_blank_out,
  output logic [1:0] src_out,
  output logic       hold_active_out,
  output logic [7:0] spi_overrun_cnt_out
);

  // state    | meaning
  // IDLE     | display blank, nothing being held
  // SHOW_SPI | latest SPI word held on the display
  // SHOW_DEC | filtered decoder value held on the display

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SCW = (DEC_STABLE_CYCLES > 1) ? $clog2(DEC_STABLE_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
  localparam logic [SCW-1:0] STAB_LOAD = SCW'(DEC_STABLE_CYCLES - 1);

  localparam logic [1:0] FORCE_AUTO  = 2'b00;
  localparam logic [1:0] FORCE_SPI   = 2'b01;
  localparam logic [1:0] FORCE_DEC   = 2'b10;
  localparam logic [1:0] SRC_NONE    = 2'b00;
  localparam logic [1:0] SRC_SPI     = 2'b01;
  localparam logic [1:0] SRC_DEC     = 2'b10;

  typedef enum logic [1:0] {IDLE, SHOW_SPI, SHOW_DEC} state_t;

  logic [1:0]     dec_s1, dec_s2, dec_filt;
  logic [SCW-1:0] stab_cnt;
  logic           dec_event;
  logic [3:0]     dec_latch;
  logic [3:0]     spi_latch;
  logic           spi_event;

  state_t         state, state_nx;
  logic [HCW-1:0] hold_cnt, hold_cnt_nx;
  logic           dec_pending, dec_pending_nx;
  logic [7:0]     overrun_nx;
  logic [3:0]     value_nx;
  logic           blank_nx;
  logic [1:0]     src_nx;

  assign dec_latch = {2'b00, dec_filt};

  // Any difference between the two sync stages means the switches moved: restart the window.
  always_ff @(posedge FPGA_clk or negedge FPGA_reset) begin
    if (!FPGA_reset) begin
      dec_s1    <= 2'b00;
      dec_s2    <= 2'b00;
      stab_cnt  <= '0;
      dec_filt  <= 2'b00;
      dec_event <= 1'b0;
      spi_latch <= 4'h0;
      spi_event <= 1'b0;
    end else begin
      dec_s1    <= dec_in;
      dec_s2    <= dec_s1;
      dec_event <= 1'b0;
      if (dec_s1 != dec_s2) begin
        stab_cnt <= STAB_LOAD;
      end else if (stab_cnt != '0) begin
        stab_cnt <= stab_cnt - 1'b1;
      end else if (dec_s2 != dec_filt) begin
        dec_filt  <= dec_s2;
        dec_event <= 1'b1;
      end
      spi_event <= spi_valid_in;
      if (spi_valid_in) spi_latch <= spi_data_in;
    end
  end

  always_comb begin
    state_nx       = state;
    hold_cnt_nx    = (hold_cnt != '0) ? hold_cnt - 1'b1 : '0;
    dec_pending_nx = dec_pending;
    overrun_nx     = spi_overrun_cnt_out;
    case (state)
      IDLE: begin
        if (spi_event) begin
          state_nx    = SHOW_SPI;
          hold_cnt_nx = HOLD_LOAD;
          if (dec_event) dec_pending_nx = 1'b1;
        end else if (dec_event) begin
          state_nx    = SHOW_DEC;
          hold_cnt_nx = HOLD_LOAD;
        end
      end
      SHOW_SPI: begin
        if (spi_event) begin
          hold_cnt_nx = HOLD_LOAD;
          if (spi_overrun_cnt_out != 8'hFF) overrun_nx = spi_overrun_cnt_out + 8'd1;
          if (dec_event) dec_pending_nx = 1'b1;
        end else if (hold_cnt == '0) begin
          // a decoder update landing on the expiry cycle is served like a pending one
          if (dec_pending || dec_event) begin
            state_nx       = SHOW_DEC;
            hold_cnt_nx    = HOLD_LOAD;
            dec_pending_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else if (dec_event) begin
          dec_pending_nx = 1'b1;
        end
      end
      SHOW_DEC: begin
        if (spi_event) begin
          state_nx    = SHOW_SPI;
          hold_cnt_nx = HOLD_LOAD;
          if (dec_event) dec_pending_nx = 1'b1;
        end else if (dec_event) begin
          hold_cnt_nx = HOLD_LOAD;
        end else if (hold_cnt == '0) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    value_nx = 4'h0;
    blank_nx = 1'b1;
    src_nx   = SRC_NONE;
    case (force_src_in)
      FORCE_AUTO: begin
        if (state_nx == SHOW_SPI) begin
          value_nx = spi_latch;
          blank_nx = 1'b0;
          src_nx   = SRC_SPI;
        end else if (state_nx == SHOW_DEC) begin
          value_nx = dec_latch;
          blank_nx = 1'b0;
          src_nx   = SRC_DEC;
        end
      end
      FORCE_SPI: begin
        value_nx = spi_latch;
        blank_nx = 1'b0;
        src_nx   = SRC_SPI;
      end
      FORCE_DEC: begin
        value_nx = dec_latch;
        blank_nx = 1'b0;
        src_nx   = SRC_DEC;
      end
      default: begin
        value_nx = 4'h0;
        blank_nx = 1'b1;
        src_nx   = SRC_NONE;
      end
    endcase
  end

  always_ff @(posedge FPGA_clk or negedge FPGA_reset) begin
    if (!FPGA_reset) begin
      state               <= IDLE;
      hold_cnt            <= '0;
      dec_pending         <= 1'b0;
      spi_overrun_cnt_out <= 8'd0;
      disp_value_out      <= 4'h0;
      disp_blank_out      <= 1'b1;
      src_out             <= SRC_NONE;
      hold_active_out     <= 1'b0;
    end else begin
      state               <= state_nx;
      hold_cnt            <= hold_cnt_nx;
      dec_pending         <= dec_pending_nx;
      spi_overrun_cnt_out <= overrun_nx;
      disp_value_out      <= value_nx;
      disp_blank_out      <= blank_nx;
      src_out             <= src_nx;
      hold_active_out     <= (state_nx != IDLE);
    end
  end

endmodule
